// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_pkg : shared FSM states and parameter defaults for fetch
// Revision 1.0
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 8;
  localparam int unsigned DEF_INSTR_WIDTH = 9;
  localparam int unsigned DEF_RESET_PC    = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_LATCH = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_pc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pc : program counter with synchronous reset, absolute load, wrap incr
// Revision 1.0
// ---------------------------------------------------------------------------
module fetch_pc
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  incr,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Load has priority; increment wraps naturally at the register width.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (incr) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= ADDR_WIDTH'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch : fetch FSM, memory handshake and instruction register feed
// Revision 1.0
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned RESET_PC    = DEF_RESET_PC
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   FETCH,
  input  logic                   JUMP,
  input  logic [ADDR_WIDTH-1:0]  JUMPADDR,
  output logic                   MEMREQ,
  output logic [ADDR_WIDTH-1:0]  MEMADDR,
  input  logic                   MEMREADY,
  input  logic [INSTR_WIDTH-1:0] MEMDATA,
  output logic                   IRLOAD,
  output logic [INSTR_WIDTH-1:0] IRDATA,
  output logic                   FETCHDONE,
  output logic                   BUSY,
  output logic [ADDR_WIDTH-1:0]  PC
);

  fetch_state_e           state_q;
  fetch_state_e           state_d;
  logic [INSTR_WIDTH-1:0] hold_q;
  logic [INSTR_WIDTH-1:0] hold_d;
  logic                   pc_load;
  logic                   pc_incr;
  logic [ADDR_WIDTH-1:0]  pc;

  fetch_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_fetch_pc (
    .clk       (CLOCK),
    .rst       (RESET),
    .load      (pc_load),
    .incr      (pc_incr),
    .load_addr (JUMPADDR),
    .pc        (pc)
  );

  // FETCH/JUMP are only honoured in IDLE and DONE; the PC load on the same
  // edge as FETCH means the following REQ already presents the jump target.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pc_load = 1'b0;
    pc_incr = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_load = JUMP;
        if (FETCH) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (MEMREADY) begin
          hold_d  = MEMDATA;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        pc_incr = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        pc_load = JUMP;
        state_d = FETCH ? S_REQ : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign MEMREQ    = (state_q == S_REQ);
  assign MEMADDR   = pc;
  assign IRLOAD    = (state_q == S_LATCH);
  assign IRDATA    = hold_q;
  assign FETCHDONE = (state_q == S_DONE);
  assign BUSY      = (state_q == S_REQ) || (state_q == S_LATCH);
  assign PC        = pc;

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that owns the program counter, reads one 9-bit instruction word per request from instruction memory through a ready-based handshake, and drives the load strobe and data of the instruction register directly downstream. The control unit requests a fetch, waits for the completion pulse, then decodes from the instruction register. Relative jumps are not supported; only absolute PC loads via JUMP.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of PC and memory address
- INSTR_WIDTH, 9, instruction word width (matches instruction register)
- RESET_PC, 0, PC value after reset

Ports:
- CLOCK  in  1  single clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- FETCH  in  1  control unit requests next instruction (sampled in IDLE and DONE only)
- JUMP  in  1  load PC from JUMPADDR (sampled in IDLE and DONE only)
- JUMPADDR  in  ADDR_WIDTH  absolute jump target
- MEMREQ  out  1  memory read request, held until MEMREADY
- MEMADDR  out  ADDR_WIDTH  read address, equals PC
- MEMREADY  in  1  memory data valid on MEMDATA this cycle
- MEMDATA  in  INSTR_WIDTH  instruction word from memory
- IRLOAD  out  1  load strobe to instruction register
- IRDATA  out  INSTR_WIDTH  data to instruction register
- FETCHDONE  out  1  one-cycle pulse: instruction register now holds new word
- BUSY  out  1  high in REQ and LATCH
- PC  out  ADDR_WIDTH  current program counter

## Operation
- States: IDLE, REQ, LATCH, DONE; all outputs registered or decoded from state only.
- IDLE: MEMREQ=0, IRLOAD=0. FETCH=1 -> REQ. JUMP=1 -> PC<=JUMPADDR (same edge as FETCH if both; REQ then uses new PC).
- REQ: MEMREQ=1, MEMADDR=PC, stable until handshake. MEMREADY=1 sampled -> capture MEMDATA into holding register, -> LATCH. MEMREADY=0 -> stay; no timeout.
- LATCH: IRLOAD=1, IRDATA=holding register; PC<=PC+1 at end of cycle, modulo 2^ADDR_WIDTH (all-ones wraps to 0). -> DONE.
- DONE: FETCHDONE=1. JUMP=1 overrides the increment (PC<=JUMPADDR). FETCH=1 -> REQ (back-to-back), else -> IDLE.
- FETCH/JUMP in REQ or LATCH ignored; MEMREADY outside REQ ignored.
- IRDATA holds last captured word when IRLOAD=0.
- RESET (any state, any cycle): next state IDLE, PC=RESET_PC, holding register 0; in-flight memory response discarded. RESET dominates FETCH/JUMP/MEMREADY.

## Timing
- Reset values: MEMREQ=0, MEMADDR=RESET_PC, IRLOAD=0, IRDATA=0, FETCHDONE=0, BUSY=0, PC=RESET_PC.
- FETCH high at edge N -> MEMREQ high cycle N+1.
- Zero-wait memory (MEMREADY in first REQ cycle): IRLOAD in cycle N+2, FETCHDONE in N+3, PC incremented visible in N+3. Each wait cycle adds one.
- Back-to-back fetch throughput: one instruction per 3 cycles with zero-wait memory.
- Instruction register updates on the edge ending the IRLOAD cycle, so it is valid whenever FETCHDONE=1.

## Structure
- Shared package: state enumeration (IDLE, REQ, LATCH, DONE), ADDR_WIDTH/INSTR_WIDTH defaults, RESET_PC default.
- One sub-module: fetch_pc (PC register: synchronous reset to RESET_PC, load, increment with wrap; load beats increment).
- Top: FSM, holding register, output decode.

## Test plan
- Reset then FETCH, MEMREADY same cycle as first MEMREQ, MEMDATA=9'h0C2 -> MEMADDR=0, IRLOAD with IRDATA=9'h0C2 two cycles after FETCH, FETCHDONE next cycle, PC=1.
- FETCH with MEMREADY delayed 3 cycles -> MEMREQ/MEMADDR stable 4 cycles, MEMDATA changing before MEMREADY not captured; FETCHDONE 6 cycles after FETCH.
- JUMP=1, JUMPADDR=8'hFF with FETCH in IDLE -> MEMADDR=8'hFF; after completion PC=8'h00 (wrap).
- FETCH held high in DONE for 3 fetches, data 9'h04C, 9'h03E, 9'h1FF -> MEMREQ re-asserted the cycle after each FETCHDONE, PC 0->1->2->3, IRDATA sequence matches.
- RESET asserted in REQ while MEMREADY=1 -> next cycle IDLE, MEMREQ=0, no IRLOAD/FETCHDONE, PC=RESET_PC.
- JUMP and FETCH pulsed during REQ/LATCH -> ignored; PC increments normally.
